dom_share_gen: RTL
==================

# dom_share_gen

Upstream masking stage for the first-order DOM AND gadget. It splits each unmasked `WIDTH`-bit input word into two Boolean shares, `is0 = x ^ m` and `is1 = m`, using an internal Galois LFSR. It also supplies the fresh `refreshing` randomness the gadget consumes alongside each share pair. Input and output use valid/ready handshakes, with a single-entry output register.

## Interface
Parameters:
- `WIDTH`, 2: number of unmasked bits per word. Bit 0 is operand a, bit 1 is operand b.
- `RND_W`, 1: number of refreshing bits per word.
- `LFSR_W`, 16: LFSR state width. `WIDTH + RND_W <= LFSR_W` is required, and elaboration fails otherwise.
- `SEED`, 16'hACE1: LFSR value loaded at reset. It must be nonzero.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block can accept a word.
- `in_data`, in, `WIDTH`: unmasked word.
- `out_valid`, out, 1: `is0`, `is1` and `refreshing` hold a valid share set.
- `out_ready`, in, 1: the downstream gadget accepts the share set.
- `is0`, out, `WIDTH`: share 0, equal to `in_data ^ m`.
- `is1`, out, `WIDTH`: share 1, equal to `m`.
- `refreshing`, out, `RND_W`: fresh randomness for the gadget's cross terms.
- `seed_valid`, in, 1: present only with `DOM_SHARE_GEN_RESEED_EN`.
- `seed_data`, in, `LFSR_W`: present only with `DOM_SHARE_GEN_RESEED_EN`.

## Operation
- LFSR is right-shifting Galois with taps `16'hB400`: `next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`.
- Bit fields of the current LFSR value:
  - mask `m = lfsr[WIDTH-1:0]`
  - `r = lfsr[WIDTH+RND_W-1:WIDTH]`
- The LFSR advances exactly once per accepted input (`in_valid & in_ready`) and never otherwise. This keeps the sequence deterministic per transaction.
- On accept, in the same edge:
  - `is1 <= m`
  - `is0 <= in_data ^ m`
  - `refreshing <= r`
  - `out_valid <= 1`
  - `lfsr <= next`
- Output state machine:
  - EMPTY (`out_valid=0`) goes to FULL on accept.
  - FULL with `out_ready=1` and no accept goes to EMPTY.
  - FULL with `out_ready=1` and an accept stays FULL with the new data.
  - FULL with `out_ready=0` holds all outputs stable.
- `in_ready = !out_valid | out_ready`. This is combinational and gives full throughput.
- The unmasked `in_data` is never stored. Only the shares are registered.
- Reset values:
  - `out_valid=0`
  - `is0=0`, `is1=0`, `refreshing=0`
  - `lfsr=SEED`
- Reset mid-transaction drops any held share set. Reset has priority over every other event in that cycle.

## Timing
- Latency is 1 cycle from accept edge to `out_valid=1`.
- Throughput is 1 word per cycle while `out_ready=1`.
- `in_ready` depends combinationally on `out_ready` only. There is no path from `in_valid` to `in_ready`.
- Outputs are driven directly from registers, with no combinational logic after the flops. This is required so the shares and randomness do not glitch into the DOM gadget's input terms.

## Configuration
- `DOM_SHARE_GEN_RESEED_EN` defined:
  - The `seed_valid` and `seed_data` ports exist.
  - When `seed_valid=1`, `lfsr <= (seed_data==0) ? SEED : seed_data`.
  - Reseed wins over the advance. An accept in the same cycle still masks with the pre-reseed LFSR value.
  - Reseed does not change `out_valid` or the output registers.
- Not defined: the ports are absent and the LFSR is seeded only by reset.

## Structure
- Package `dom_pkg`:
  - `LFSR_TAPS` (16'hB400)
  - `DEFAULT_SEED` (16'hACE1)
  - a `share_pair_t` struct containing `is0` and `is1`
- Sub-module `lfsr_galois`, with ports `clk`, `rst`, `advance`, `load`, `load_val` and `state`.
- `dom_share_gen` contains the handshake logic, the output register and the masking XOR.

## Test plan
- Reset, then accept `in_data=2'b11` with `out_ready=1`. Next cycle requires:
  - `is1=2'b01` and `is0=2'b10`
  - `refreshing=0`
  - LFSR equal to 16'hE270
- A second accept of `2'b10` requires `is1=2'b00`, `is0=2'b10`, `refreshing=0` and LFSR equal to 16'h7138.
- Hold `out_ready=0` for 5 cycles while `out_valid=1`. Required:
  - `in_ready=0`
  - outputs stable
  - LFSR unchanged
- Then pulse `out_ready`: exactly one transfer, and `out_valid` drops when no new input arrives.
- Stream 100 random words with random `out_ready`. For every transfer, check `is0 ^ is1 == in_data` and that no word is lost or duplicated.
- Assert `rst` while FULL. Next cycle requires `out_valid=0`, all outputs 0 and LFSR equal to 16'hACE1.
- With `DOM_SHARE_GEN_RESEED_EN`:
  - `seed_valid` with `seed_data=0` gives LFSR 16'hACE1.
  - `seed_data=16'h1234` together with an accept uses the old mask, then LFSR becomes 16'h1234.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared constants and types for the DOM share generator.
package dom_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Width of one share in the default two-operand (a, b) configuration.
  localparam int unsigned SHARE_W = 2;

  typedef struct packed {
    logic [SHARE_W-1:0] is0;
    logic [SHARE_W-1:0] is1;
  } share_pair_t;

  // Occupancy of the single-entry output register.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/dom_share_gen_lfsr.sv
// Right-shifting Galois LFSR that steps only on request; an optional load
// takes priority over the step.
module lfsr_galois #(
  parameter int unsigned       W    = 16,
  parameter logic [W-1:0]      TAPS = W'(16'hB400),
  parameter logic [W-1:0]      SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  logic [W-1:0] next_state;

  // Galois step: shift right, fold the taps in when the outgoing bit is set.
  always_comb begin
    next_state = (state >> 1) ^ (state[0] ? TAPS : '0);
  end

  // State register: reset, then load, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/dom_share_gen.sv
// Splits each unmasked word into two Boolean shares (x ^ m, m) and supplies
// refreshing randomness for the downstream DOM AND gadget.
// Optional feature macro: DOM_SHARE_GEN_RESEED_EN (adds seed_valid/seed_data).
module dom_share_gen
  import dom_pkg::*;
#(
  parameter int unsigned        WIDTH  = 2,
  parameter int unsigned        RND_W  = 1,
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  is0,
  output logic [WIDTH-1:0]  is1,
  output logic [RND_W-1:0]  refreshing
`ifdef DOM_SHARE_GEN_RESEED_EN
  ,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data
`endif
);

  if (WIDTH + RND_W > LFSR_W) begin : g_width_check
    $error("dom_share_gen: WIDTH + RND_W must not exceed LFSR_W");
  end
  if (SEED == '0) begin : g_seed_check
    $error("dom_share_gen: SEED must be nonzero");
  end

  out_state_t        state;
  logic              accept;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val;
  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr_bits;

  assign out_valid = (state == OUT_FULL);
  assign in_ready  = (state == OUT_EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;

  // Upper LFSR bits only feed the feedback; they are not drawn as mask or randomness.
  assign unused_lfsr_bits = ^lfsr_state;

`ifdef DOM_SHARE_GEN_RESEED_EN
  // An all-zero seed would lock the LFSR, so fall back to the reset seed.
  assign lfsr_load     = seed_valid;
  assign lfsr_load_val = (seed_data == '0) ? SEED : seed_data;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS)),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .advance  (accept),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .state    (lfsr_state)
  );

  // Output register: mask on accept, drain on out_ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OUT_EMPTY;
      is0        <= '0;
      is1        <= '0;
      refreshing <= '0;
    end else if (accept) begin
      state      <= OUT_FULL;
      is1        <= lfsr_state[WIDTH-1:0];
      is0        <= in_data ^ lfsr_state[WIDTH-1:0];
      refreshing <= lfsr_state[WIDTH+RND_W-1:WIDTH];
    end else if (out_ready) begin
      state      <= OUT_EMPTY;
    end
  end

endmodule
